// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency unified memory between instruction fetch and data load/store.
//  Optional feature macro: MEM_ARB_RR_EN (alternating priority when both ports request in IDLE;
//  undefined = data always beats fetch).
//  Ports: clk, rst_n (async active-low); fetch if_req/if_addr -> if_ack/if_rdata;
//  data d_re/d_we/d_addr/d_wdata -> d_ack/d_rdata; halt blocks new fetches;
//  memory mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata; status busy/halted.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              halted
);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          gnt_d;
  logic          d_req, if_ok, take_d;
  assign d_req = d_re | d_we;
  assign if_ok = if_req & ~halt;
`ifdef MEM_ARB_RR_EN
  // last_d remembers who won the previous grant so a contested IDLE alternates
  logic last_d;
  assign take_d = d_req & (~if_ok | ~last_d);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_d <= 1'b0;
    else if (state == IDLE && (d_req | if_ok)) last_d <= take_d;
`else
  assign take_d = d_req;
`endif
  assign busy   = state != IDLE;
  assign halted = rst_n & halt & (state == IDLE) & ~d_req;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_d     <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (d_req | if_ok) begin
          state     <= ACCESS;
          cnt       <= '0;
          gnt_d     <= take_d;
          mem_en    <= 1'b1;
          mem_we    <= take_d & d_we;
          mem_addr  <= take_d ? d_addr : if_addr;
          mem_wdata <= take_d ? d_wdata : mem_wdata;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(LATENCY - 1)) begin
            state    <= RESP;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            d_ack    <= gnt_d;
            if_ack   <= ~gnt_d;
            // writes (including simultaneous re+we) leave d_rdata untouched
            d_rdata  <= (gnt_d & ~mem_we) ? mem_rdata : d_rdata;
            if_rdata <= gnt_d ? if_rdata : mem_rdata;
          end
        end
        RESP: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a table of transactions and an ack scoreboard.
module tb_mem_arbiter;
  localparam int LAT = 2;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, d_re = 0, d_we = 0, halt = 0;
  logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic if_ack, d_ack, mem_en, mem_we, busy, halted;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:1023];
  int cyc = 0, start_cyc = 0, en_cnt = 0, pass_n = 0, total_n = 0;

  typedef struct {
    logic ifr; logic [15:0] ia;
    logic dr, dw; logic [15:0] da, dwd;
    logic [15:0] exp_if, exp_d;
  } vec_t;
  typedef struct {
    logic is_d, we; logic [15:0] addr, wdata, rdata; int lat;
  } exp_t;
  exp_t q[$];
  exp_t e;
  vec_t tbl [7];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .halt(halt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[9:0]] <= mem_wdata;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] x);
    total_n++;
    if (a === x) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", n, a, x);
  endtask

  always @(negedge clk) begin
    if (!rst_n) en_cnt = 0;
    else begin
      if (mem_en) begin
        if (q.size() == 0) check("spurious_mem_en", 1, 0);
        else begin
          check("mem_addr", mem_addr, q[0].addr);
          check("mem_we", mem_we, q[0].we);
          if (q[0].we) check("mem_wdata", mem_wdata, q[0].wdata);
        end
        en_cnt++;
      end
      if (if_ack || d_ack) begin
        if (q.size() == 0) check("spurious_ack", 1, 0);
        else begin
          e = q.pop_front();
          check("ack_port", d_ack, e.is_d);
          check("single_ack", if_ack & d_ack, 0);
          check("ack_latency", cyc - start_cyc, e.lat);
          check("en_cycles", en_cnt, LAT);
          check(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic push(input logic is_d, input logic we, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] rd, input int lat);
    exp_t x;
    x.is_d = is_d; x.we = we; x.addr = a; x.wdata = wd; x.rdata = rd; x.lat = lat;
    q.push_back(x);
  endtask

  task automatic wait_q(input int bound, input bit drop);
    int n = 0;
    while (q.size() > 0 && n < bound) begin
      @(negedge clk); #1;
      n++;
      if (drop && if_ack) if_req = 0;
      if (drop && d_ack) begin d_re = 0; d_we = 0; end
    end
    if (q.size() > 0) check("ack_timeout", q.size(), 0);
    q.delete();
    if_req = 0; d_re = 0; d_we = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat = LAT + 1;
    @(negedge clk);
    start_cyc = cyc;
    if (v.dr || v.dw) begin push(1, v.dw, v.da, v.dwd, v.exp_d, lat); lat = 2 * LAT + 3; end
    if (v.ifr) push(0, 0, v.ia, 0, v.exp_if, lat);
    if_req = v.ifr; if_addr = v.ia;
    d_re = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dwd;
    wait_q(40, 1);
    check("hold_if_rdata", if_rdata, v.exp_if);
    check("hold_d_rdata", d_rdata, v.exp_d);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[10'h010] = 16'hB123;
    mem[10'h020] = 16'h1234;
    mem[10'h100] = 16'h5A5A;
    tbl[0] = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hB123, 16'h0000};
    tbl[1] = '{1, 16'h0020, 1, 0, 16'h0100, 16'h0000, 16'h1234, 16'h5A5A};
    tbl[2] = '{0, 16'h0000, 0, 1, 16'h0040, 16'hBEEF, 16'h1234, 16'h5A5A};
    tbl[3] = '{0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 16'h1234, 16'hBEEF};
    tbl[4] = '{0, 16'h0000, 1, 1, 16'h0050, 16'h7777, 16'h1234, 16'hBEEF};
    tbl[5] = '{1, 16'h0050, 0, 0, 16'h0000, 16'h0000, 16'h7777, 16'hBEEF};
    tbl[6] = '{0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 16'h7777, 16'h1234};

    repeat (3) @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_acks", {if_ack, d_ack}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    rst_n = 1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // reset in the middle of an access: everything clears at once, no late ack
    @(negedge clk);
    start_cyc = cyc;
    push(1, 0, 16'h0040, 0, 16'hBEEF, LAT + 1);
    d_re = 1; d_addr = 16'h0040;
    @(negedge clk);
    check("pre_abort_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check("abort_mem_en", mem_en, 0);
    check("abort_busy", busy, 0);
    check("abort_acks", {if_ack, d_ack}, 0);
    check("abort_d_rdata", d_rdata, 0);
    d_re = 0;
    q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_abort_idle", {busy, if_ack, d_ack, mem_en}, 0);
    end

    // both ports held continuously straight after reset: data wins first
    @(negedge clk);
    start_cyc = cyc;
`ifdef MEM_ARB_RR_EN
    push(1, 0, 16'h0020, 0, 16'h1234, LAT + 1);
    push(0, 0, 16'h0010, 0, 16'hB123, 2 * LAT + 3);
    push(1, 0, 16'h0020, 0, 16'h1234, 3 * LAT + 5);
    push(0, 0, 16'h0010, 0, 16'hB123, 4 * LAT + 7);
`else
    push(1, 0, 16'h0020, 0, 16'h1234, LAT + 1);
    push(1, 0, 16'h0020, 0, 16'h1234, 2 * LAT + 3);
    push(1, 0, 16'h0020, 0, 16'h1234, 3 * LAT + 5);
`endif
    if_req = 1; if_addr = 16'h0010; d_re = 1; d_addr = 16'h0020;
    wait_q(60, 0);

    // halt blocks a pending fetch
    @(negedge clk);
    halt = 1; if_req = 1; if_addr = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_no_en", mem_en, 0);
      check("halt_halted", halted, 1);
    end
    start_cyc = cyc;
    push(0, 0, 16'h0010, 0, 16'hB123, LAT + 1);
    halt = 0;
    wait_q(40, 1);

    // halt rising mid-fetch: the fetch still completes
    @(negedge clk);
    start_cyc = cyc;
    push(0, 0, 16'h0020, 0, 16'h1234, LAT + 1);
    if_req = 1; if_addr = 16'h0020;
    @(negedge clk);
    halt = 1;
    wait_q(40, 1);
    @(negedge clk);
    check("halted_after_fetch", halted, 1);
    check("idle_after_fetch", busy, 0);

    // data access proceeds under halt and clears halted while pending
    start_cyc = cyc;
    push(1, 0, 16'h0010, 0, 16'hB123, LAT + 1);
    d_re = 1; d_addr = 16'h0010;
    #1 check("halted_data_pending", halted, 0);
    wait_q(40, 1);
    halt = 0;
    repeat (2) @(negedge clk);
    check("final_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
